// File: rtl/clic_pkg.sv
// clic_pkg: shared types and constants for the CLIC preemption controller.
//   prio_t / index_t : default-width priority level and source index
//   state_t          : offer FSM state (IDLE, OFFER)
//   PRIO_BASE        : thread (base) level, never taken as an interrupt
//   prio_max()       : larger of two priority levels
package clic_pkg;

  localparam int unsigned PRIO_BITS_DEFAULT  = 3;
  localparam int unsigned INDEX_BITS_DEFAULT = 2;

  typedef logic [PRIO_BITS_DEFAULT-1:0]  prio_t;
  typedef logic [INDEX_BITS_DEFAULT-1:0] index_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int unsigned PRIO_BASE = 0;

  function automatic int unsigned prio_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clic_prio_stack.sv
// clic_prio_stack: DEPTH-entry LIFO of interrupted priority levels.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : push din / pop top; both together replaces the top entry
//   din        : value to push
//   top        : current top entry ('0 when empty)
//   count      : number of valid entries
//   full/empty : count == DEPTH / count == 0
module clic_prio_stack
  import clic_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Entries are addressed by comparing against the count so no index
  // narrower/wider than the array ever reaches the memory.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) top = mem_q[i];
    end
  end

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && pop && !empty) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i + 1) == count_q) mem_d[i] = din;
      end
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_q) mem_d[i] = din;
      end
      count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/clic_preempt_ctrl.sv
// clic_preempt_ctrl: preemption control downstream of the CLIC arbiter.
// Compares the arbiter winner against the running handler's priority,
// offers preempting interrupts to the core over valid/ready, and keeps a
// LIFO of interrupted levels so nested returns restore the right level.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/index/prio  : arbiter winner
//   irq_valid/index/prio  : offer to core (held while irq_valid)
//   irq_ready             : core accepts the offer (handler entry)
//   ret_valid             : core returns from a handler (1-cycle pulse)
//   cur_prio              : priority of running context
//   depth                 : current nesting level
//   underflow             : sticky, return seen with depth == 0
// Optional: `define CLIC_THRESHOLD_EN adds input th_prio; offer then needs
//   req_prio > max(cur_prio, th_prio). th_prio is never stacked.
module clic_preempt_ctrl
  import clic_pkg::*;
#(
  parameter int unsigned PRIO_BITS  = 3,
  parameter int unsigned INDEX_BITS = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [INDEX_BITS-1:0]        req_index,
  input  logic [PRIO_BITS-1:0]         req_prio,
`ifdef CLIC_THRESHOLD_EN
  input  logic [PRIO_BITS-1:0]         th_prio,
`endif
  output logic                         irq_valid,
  output logic [INDEX_BITS-1:0]        irq_index,
  output logic [PRIO_BITS-1:0]         irq_prio,
  input  logic                         irq_ready,
  input  logic                         ret_valid,
  output logic [PRIO_BITS-1:0]         cur_prio,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   irq_index_q, irq_index_d;
  logic [PRIO_BITS-1:0]    irq_prio_q, irq_prio_d;
  logic [PRIO_BITS-1:0]    cur_prio_q, cur_prio_d;
  logic                    underflow_q, underflow_d;

  logic                    stk_push, stk_pop;
  logic [PRIO_BITS-1:0]    stk_top;
  logic [CW-1:0]           stk_count;
  logic                    stk_full, stk_empty;

  logic [PRIO_BITS-1:0]    gate_prio;
  logic                    offer_ok;
  logic                    accept;

`ifdef CLIC_THRESHOLD_EN
  assign gate_prio = PRIO_BITS'(prio_max(int'(cur_prio_q), int'(th_prio)));
`else
  assign gate_prio = cur_prio_q;
`endif

  assign offer_ok = req_valid && (req_prio > gate_prio) && !stk_full;
  assign accept   = (state_q == OFFER) && irq_ready;

  // Tail chain (accept + return together): the push of the current level
  // and the pop cancel, so the stack is left alone and only cur_prio moves.
  assign stk_push = accept && !ret_valid;
  assign stk_pop  = ret_valid && !accept && !stk_empty;

  clic_prio_stack #(
    .DEPTH (DEPTH),
    .WIDTH (PRIO_BITS)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (cur_prio_q),
    .top   (stk_top),
    .count (stk_count),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d     = state_q;
    irq_index_d = irq_index_q;
    irq_prio_d  = irq_prio_q;
    cur_prio_d  = cur_prio_q;
    // A return at base level is always an error, even alongside an accept.
    underflow_d = underflow_q | (ret_valid & stk_empty);

    unique case (state_q)
      IDLE: begin
        if (offer_ok) begin
          state_d     = OFFER;
          irq_index_d = req_index;
          irq_prio_d  = req_prio;
        end
      end
      OFFER: begin
        if (irq_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept)       cur_prio_d = irq_prio_q;
    else if (stk_pop) cur_prio_d = stk_top;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      irq_index_q <= '0;
      irq_prio_q  <= '0;
      cur_prio_q  <= PRIO_BITS'(PRIO_BASE);
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_index_q <= irq_index_d;
      irq_prio_q  <= irq_prio_d;
      cur_prio_q  <= cur_prio_d;
      underflow_q <= underflow_d;
    end
  end

  assign irq_valid = (state_q == OFFER);
  assign irq_index = irq_index_q;
  assign irq_prio  = irq_prio_q;
  assign cur_prio  = cur_prio_q;
  assign depth     = stk_count;
  assign underflow = underflow_q;

endmodule
